multicycle_controller: RTL and testbench

- Moore-style FSM that sequences the shared 16-bit multicycle datapath: one memory port, one ALU, PC/IR/register-file write enables.
- Replaces the single-cycle control path. Takes op/funct from the IR and zero from the ALU, and drives the per-cycle datapath selects.
- Waits on a memory ready handshake.
- Keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/aludec.sv | 31 +++
 rtl/multicycle_controller.sv | 145 ++++++++++++++
 tb/tb_multicycle_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode map,
// ALU operation codes and datapath select constants.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_TWO  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] FUNCT_ADD = 4'h0;
  localparam logic [3:0] FUNCT_SUB = 4'h1;
  localparam logic [3:0] FUNCT_AND = 4'h2;
  localparam logic [3:0] FUNCT_OR  = 4'h3;
  localparam logic [3:0] FUNCT_SLT = 4'h4;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic op_defined(input logic [2:0] o);
    return (o <= OP_J);
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's aluop plus the R-type funct field to an
// ALU operation. Unknown funct codes fall back to ADD.
module aludec
  import cpu_pkg::*;
(
  input  logic [3:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  // aluop selects a fixed operation or defers to the funct field
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle datapath, with memory ready
// handshake, illegal-opcode pulse and a retired-instruction counter.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   op,
  input  logic [3:0]   funct,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         pcen,
  output logic         iord,
  output logic         irwrite,
  output logic         memwrite,
  output logic         memtoreg,
  output logic         regdst,
  output logic         regwrite,
  output logic         alusrca,
  output logic [1:0]   alusrcb,
  output logic [1:0]   pcsrc,
  output logic [2:0]   alucontrol,
  output logic         illegal,
  output logic [n-1:0] instret
);

  state_t     state;
  logic [1:0] aluop;
  logic       pcen_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       retire_s;

  // An instruction retires on the edge that carries its last state into FETCH
  always_comb begin
    retire_s = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_s = 1'b1;
      S_MEMWR: retire_s = mem_ready;
      default: retire_s = 1'b0;
    endcase
  end

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      instret <= {n{1'b0}};
    end else begin
      case (state)
        S_FETCH: if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEXEC;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    if (mem_ready) state <= S_MEMWB;
        S_MEMWR:    if (mem_ready) state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEXEC: state <= S_ADDIWB;
        default:    state <= S_FETCH;
      endcase
      if (retire_s) instret <= instret + n'(1);
    end
  end

  // Per-state datapath controls; only FETCH and BRANCH look at inputs
  always_comb begin
    pcen_s     = 1'b0;
    iord       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        alusrcb   = SRCB_TWO;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMM2;
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pcen_s  = zero;
      end
      S_JUMP: begin
        pcsrc  = PCSRC_JUMP;
        pcen_s = 1'b1;
      end
      default: pcen_s = 1'b0;
    endcase
  end

  // Write enables are gated by reset directly so they fall without waiting for a clock
  assign pcen     = reset & pcen_s;
  assign irwrite  = reset & irwrite_s;
  assign memwrite = reset & memwrite_s;
  assign regwrite = reset & regwrite_s;
  assign illegal  = (state == S_DECODE) && !op_defined(op);

  aludec u_aludec (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// control vectors and compared against the controller every cycle.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] funct = 4'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;

  logic pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [15:0] instret;

  logic s_pcen, s_iord, s_irwrite, s_memwrite, s_memtoreg, s_regdst, s_regwrite, s_alusrca, s_illegal;
  logic [1:0] s_alusrcb, s_pcsrc;
  logic [2:0] s_alucontrol;
  logic [3:0] instret_small;

  multicycle_controller #(.n(16)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .instret(instret)
  );

  // Narrow counter instance so wrap-around is reached within a short run
  multicycle_controller #(.n(4)) dut_small (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(s_pcen), .iord(s_iord), .irwrite(s_irwrite), .memwrite(s_memwrite), .memtoreg(s_memtoreg),
    .regdst(s_regdst), .regwrite(s_regwrite), .alusrca(s_alusrca), .alusrcb(s_alusrcb), .pcsrc(s_pcsrc),
    .alucontrol(s_alucontrol), .illegal(s_illegal), .instret(instret_small)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_vec = 16'd0;
  logic exp_valid = 1'b0;
  logic [15:0] exp_instret = 16'd0;
  logic [15:0] model_cnt = 16'd0;
  int cyc_cnt = 0;
  int n_irw = 0, n_mw = 0, n_rw = 0, n_pcen = 0;

  wire [15:0] dut_vec = {pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
                         alusrcb, pcsrc, alucontrol, illegal};

  function automatic logic [15:0] v(input logic pc, input logic ia, input logic irw, input logic mw,
                                    input logic m2r, input logic rd, input logic rw, input logic asa,
                                    input logic [1:0] asb, input logic [1:0] ps, input logic [2:0] alu,
                                    input logic ill);
    return {pc, ia, irw, mw, m2r, rd, rw, asa, asb, ps, alu, ill};
  endfunction

  function automatic logic [2:0] rt_alu(input logic [3:0] f);
    case (f)
      4'd1: return 3'b110;
      4'd2: return 3'b000;
      4'd3: return 3'b001;
      4'd4: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Every-cycle comparison of controls and counters against the model
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL ctl t=%0t op=%0d got=%b expected=%b", $time, op, dut_vec, exp_vec);
      end
      checks++;
      if (instret !== exp_instret) begin
        failures++;
        $display("FAIL instret t=%0t got=%0d expected=%0d", $time, instret, exp_instret);
      end
      checks++;
      if (instret_small !== exp_instret[3:0]) begin
        failures++;
        $display("FAIL instret_small t=%0t got=%0d expected=%0d", $time, instret_small, exp_instret[3:0]);
      end
      n_irw  += int'(irwrite);
      n_mw   += int'(memwrite);
      n_rw   += int'(regwrite);
      n_pcen += int'(pcen);
    end
  end

  task automatic step(input logic mr, input logic [15:0] e);
    mem_ready = mr;
    exp_vec = e;
    exp_valid = 1'b1;
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [2:0] o, input int wf);
    for (int i = 0; i < wf; i++) step(1'b0, v(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    step(1'b1, v(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0));
    step(rb(), v(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,(o >= 3'd6)));
  endtask

  task automatic run_instr(input logic [2:0] o, input logic [3:0] f, input logic z, input int wf, input int wm);
    op = o; funct = f; zero = z;
    cyc_cnt = 0; n_irw = 0; n_mw = 0; n_rw = 0; n_pcen = 0;
    exp_instret = model_cnt;
    fetch_decode(o, wf);
    case (o)
      3'd0: begin
        step(rb(), v(0,0,0,0,0,0,0,1,2'b00,2'b00,rt_alu(f),0));
        step(rb(), v(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,0));
      end
      3'd1: begin
        step(rb(), v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
        for (int i = 0; i < wm; i++) step(1'b0, v(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0));
        step(1'b1, v(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0));
        step(rb(), v(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,0));
      end
      3'd2: begin
        step(rb(), v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
        for (int i = 0; i < wm; i++) step(1'b0, v(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0));
        step(1'b1, v(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0));
      end
      3'd3: step(rb(), v(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
      3'd4: begin
        step(rb(), v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
        step(rb(), v(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,0));
      end
      3'd5: step(rb(), v(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0));
      default: ;
    endcase
    if (o <= 3'd5) model_cnt = model_cnt + 16'd1;
  endtask

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_instret", int'(instret), 0);
    chk("reset_illegal", int'(illegal), 0);
    chk("reset_pcen", int'(pcen), 0);
    chk("reset_irwrite", int'(irwrite), 0);
    chk("reset_regwrite", int'(regwrite), 0);
    chk("reset_memwrite", int'(memwrite), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(3'd0, 4'd0, 1'b0, 0, 0);
    chk("add_cycles", cyc_cnt, 4);
    chk("add_regwrite_cnt", n_rw, 1);
    #0 chk("add_instret", int'(instret), 1);

    run_instr(3'd1, 4'd0, 1'b0, 2, 3);
    chk("lw_cycles", cyc_cnt, 10);
    chk("lw_irwrite_cnt", n_irw, 1);
    chk("lw_pcen_cnt", n_pcen, 1);
    chk("lw_regwrite_cnt", n_rw, 1);

    run_instr(3'd2, 4'd0, 1'b0, 0, 1);
    chk("sw_cycles", cyc_cnt, 5);
    chk("sw_memwrite_cnt", n_mw, 2);
    chk("sw_regwrite_cnt", n_rw, 0);

    run_instr(3'd3, 4'd0, 1'b1, 0, 0);
    chk("beq_taken_cycles", cyc_cnt, 3);
    chk("beq_taken_pcen_cnt", n_pcen, 2);
    run_instr(3'd3, 4'd0, 1'b0, 0, 0);
    chk("beq_not_taken_cycles", cyc_cnt, 3);
    chk("beq_not_taken_pcen_cnt", n_pcen, 1);
    chk("beq_instret", int'(instret), 5);

    run_instr(3'd6, 4'd0, 1'b0, 0, 0);
    chk("illegal_cycles", cyc_cnt, 2);
    chk("illegal_instret", int'(instret), 5);
    chk("illegal_writes", n_rw + n_mw, 0);

    for (int k = 0; k < 300; k++)
      run_instr(3'($urandom_range(7, 0)), 4'($urandom_range(7, 0)), rb(),
                $urandom_range(2, 0), $urandom_range(2, 0));

    while (model_cnt[3:0] != 4'hF) run_instr(3'd5, 4'd0, 1'b0, 0, 0);
    run_instr(3'd5, 4'd0, 1'b0, 0, 0);
    chk("small_wrap", int'(instret_small), 0);
    chk("wide_after_wrap", int'(instret), int'(model_cnt));

    // Abort a store mid-wait with reset
    op = 3'd2; funct = 4'd0;
    exp_instret = model_cnt;
    fetch_decode(3'd2, 0);
    step(rb(), v(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
    step(1'b0, v(0,1,0,1,0,0,0,0,2'b00,2'b00,3'b010,0));
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    #1 chk("memwr_before_reset", int'(memwrite), 1);
    reset = 1'b0;
    #1 chk("memwr_async_drop", int'(memwrite), 0);
    chk("reset_mid_instret", int'(instret), 0);
    chk("reset_mid_iord", int'(iord), 0);
    @(negedge clk);
    chk("reset_mid_hold_memwrite", int'(memwrite), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_cnt = 16'd0;
    run_instr(3'd4, 4'd0, 1'b0, 1, 0);
    chk("addi_after_reset_cycles", cyc_cnt, 5);
    run_instr(3'd0, 4'd2, 1'b0, 0, 0);
    exp_valid = 1'b0;
    chk("instret_after_reset", int'(instret), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
